// File: rtl/tdc_fifo_write_arbiter.sv
// Round-robin arbiter that shares one FIFO write port between N_CH TDC channels.
// Holds wr_en until the FIFO writer reports done, with a timeout abort for stuck writes.
module tdc_fifo_write_arbiter #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 4000,
  parameter int unsigned TMR_W   = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           req,
  input  logic [N_CH*DATA_W-1:0]    data_in,
  input  logic                      fifo_full,
  input  logic                      f_FIFO_writing_done,
  output logic                      wr_en,
  output logic [DATA_W-1:0]         wr_data,
  output logic [$clog2(N_CH)-1:0]   grant_id,
  output logic [N_CH-1:0]           ack,
  output logic                      timeout_err,
  output logic                      busy
);

  localparam int unsigned ID_W = $clog2(N_CH);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RELEASE
  } state_t;

  state_t            state, state_n;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_n;
  logic [TMR_W-1:0]  timer, timer_n;
  logic              wr_en_n, timeout_err_n, busy_n;
  logic [DATA_W-1:0] wr_data_n;
  logic [ID_W-1:0]   grant_id_n;
  logic [N_CH-1:0]   ack_n;

  logic [DATA_W-1:0] ch_data [N_CH];
  logic [ID_W-1:0]   sel_id, scan_id;
  logic              sel_found;

  for (genvar g = 0; g < N_CH; g++) begin : g_unpack
    assign ch_data[g] = data_in[g*DATA_W +: DATA_W];
  end

  // Scan starts one past the last served channel so it gets lowest priority next.
  always_comb begin
    sel_id    = '0;
    scan_id   = '0;
    sel_found = 1'b0;
    for (int unsigned off = 1; off <= N_CH; off++) begin
      scan_id = ID_W'((32'(rr_ptr) + off) % N_CH);
      if (!sel_found && req[scan_id]) begin
        sel_found = 1'b1;
        sel_id    = scan_id;
      end
    end
  end

  always_comb begin
    state_n       = state;
    rr_ptr_n      = rr_ptr;
    timer_n       = timer;
    wr_en_n       = wr_en;
    wr_data_n     = wr_data;
    grant_id_n    = grant_id;
    ack_n         = '0;
    timeout_err_n = 1'b0;

    case (state)
      IDLE: begin
        if (sel_found && !fifo_full) begin
          state_n    = WRITE;
          wr_en_n    = 1'b1;
          grant_id_n = sel_id;
          wr_data_n  = ch_data[sel_id];
          timer_n    = '0;
        end
      end
      WRITE: begin
        // Completion takes priority over a timeout reached in the same cycle.
        if (f_FIFO_writing_done) begin
          state_n         = RELEASE;
          wr_en_n         = 1'b0;
          ack_n[grant_id] = 1'b1;
          rr_ptr_n        = grant_id;
        end else if (timer == TMR_W'(TIMEOUT)) begin
          state_n       = RELEASE;
          wr_en_n       = 1'b0;
          timeout_err_n = 1'b1;
          rr_ptr_n      = grant_id;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      RELEASE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        wr_en_n = 1'b0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= ID_W'(N_CH - 1);
      timer       <= '0;
      wr_en       <= 1'b0;
      wr_data     <= '0;
      grant_id    <= '0;
      ack         <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_ptr_n;
      timer       <= timer_n;
      wr_en       <= wr_en_n;
      wr_data     <= wr_data_n;
      grant_id    <= grant_id_n;
      ack         <= ack_n;
      timeout_err <= timeout_err_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_tdc_fifo_write_arbiter.sv
// Bench for tdc_fifo_write_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a behavioural model of the arbitration rules.
module tb_tdc_fifo_write_arbiter;

  localparam int N_CH    = 4;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 8;
  localparam int TMR_W   = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] data_in;
  logic        fifo_full;
  logic        done;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [1:0]  grant_id;
  logic [3:0]  ack;
  logic        timeout_err;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int ack_total = 0;

  // Model: phase 0 = idle, 1 = word being written, 2 = one-cycle release
  int          m_phase, m_rr, m_timer, m_gid;
  logic        m_wr_en, m_to;
  logic [15:0] m_data;
  logic [3:0]  m_ack;

  always #5 clk = ~clk;

  tdc_fifo_write_arbiter #(
    .N_CH(N_CH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .TMR_W(TMR_W)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .fifo_full(fifo_full),
    .f_FIFO_writing_done(done), .wr_en(wr_en), .wr_data(wr_data),
    .grant_id(grant_id), .ack(ack), .timeout_err(timeout_err), .busy(busy)
  );

  task automatic model_update();
    bit found;
    if (rst) begin
      m_phase = 0; m_rr = N_CH - 1; m_timer = 0; m_gid = 0;
      m_wr_en = 1'b0; m_to = 1'b0; m_data = '0; m_ack = '0;
    end else begin
      m_ack = '0;
      m_to  = 1'b0;
      if (m_phase == 0) begin
        if (req != 0 && !fifo_full) begin
          found = 1'b0;
          for (int k = 1; k <= N_CH; k++) begin
            if (!found && req[(m_rr + k) % N_CH]) begin
              found = 1'b1;
              m_gid = (m_rr + k) % N_CH;
            end
          end
          m_data  = data_in[m_gid*DATA_W +: DATA_W];
          m_wr_en = 1'b1;
          m_timer = 0;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (done) begin
          m_ack = 4'(1 << m_gid); m_rr = m_gid; m_wr_en = 1'b0; m_phase = 2;
        end else if (m_timer == TIMEOUT) begin
          m_to = 1'b1; m_rr = m_gid; m_wr_en = 1'b0; m_phase = 2;
        end else begin
          m_timer++;
        end
      end else begin
        m_phase = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    ack_total += $countones(ack);
  endtask

  task automatic wait_wr_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (wr_en) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; done = 1'b0; fifo_full = 1'b0; data_in = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'hF; done = 1'b1; fifo_full = 1'b0; data_in = {$urandom, $urandom};
    step();
    step();
    n_cmp++;
    if ({wr_en, wr_data, grant_id, ack, timeout_err, busy} !== 25'd0)
      $display("FAIL reset_outputs got=%h exp=%h",
               {wr_en, wr_data, grant_id, ack, timeout_err, busy}, 25'd0);
    rst = 1'b0; req = '0; done = 1'b0;
    step();
    n_cmp++;
    if ({wr_en, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_idle got=%b exp=00", {wr_en, busy});
    end
  endtask

  task automatic test_single_write();
    int hi = 0;
    int a0;
    do_reset();
    data_in = {$urandom, $urandom};
    data_in[15:0] = 16'hA5A5;
    req = 4'b0001;
    a0 = ack_total;
    step();
    n_cmp++;
    if ({wr_en, grant_id, wr_data} !== {1'b1, 2'd0, 16'hA5A5}) begin
      n_err++;
      $display("FAIL single_grant got=%h exp=%h", {wr_en, grant_id, wr_data}, {1'b1, 2'd0, 16'hA5A5});
    end
    for (int i = 0; i < 3; i++) begin
      if (wr_en) hi++;
      data_in = {$urandom, $urandom};
      step();
    end
    if (wr_en) hi++;
    n_cmp++;
    if (wr_data !== 16'hA5A5) begin
      n_err++;
      $display("FAIL single_data_frozen got=%h exp=a5a5", wr_data);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    req = '0;
    n_cmp++;
    if (hi != 4) begin
      n_err++;
      $display("FAIL single_wr_en_cycles got=%0d exp=4", hi);
    end
    n_cmp++;
    if ({wr_en, ack, timeout_err, busy} !== {1'b0, 4'b0001, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL single_ack got=%b exp=%b", {wr_en, ack, timeout_err, busy}, {1'b0, 4'b0001, 1'b0, 1'b1});
    end
    step();
    n_cmp++;
    if ({ack, busy} !== 5'b0 || ack_total - a0 != 1) begin
      n_err++;
      $display("FAIL single_release got=%b acks=%0d exp=00000 acks=1", {ack, busy}, ack_total - a0);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int a0, eg;
    logic [15:0] ed;
    do_reset();
    req = 4'hF;
    a0 = ack_total;
    for (int g = 0; g < 5; g++) begin
      data_in = {$urandom, $urandom};
      eg = g % N_CH;
      ed = data_in[eg*DATA_W +: DATA_W];
      wait_wr_en(ok);
      n_cmp++;
      if (!ok || {grant_id, wr_data} !== {2'(eg), ed}) begin
        n_err++;
        $display("FAIL rr_grant%0d got=%h exp=%h waited_ok=%0d", g, {grant_id, wr_data}, {2'(eg), ed}, ok);
      end
      step();
      done = 1'b1;
      step();
      done = 1'b0;
      n_cmp++;
      if (ack !== 4'(1 << eg)) begin
        n_err++;
        $display("FAIL rr_ack%0d got=%b exp=%b", g, ack, 4'(1 << eg));
      end
    end
    req = '0;
    step();
    n_cmp++;
    if (ack_total - a0 != 5) begin
      n_err++;
      $display("FAIL rr_ack_count got=%0d exp=5", ack_total - a0);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [1:0] exp_ids [3] = '{2'd2, 2'd0, 2'd2};
    logic [3:0] reqs    [3] = '{4'b0100, 4'b0101, 4'b0100};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      req = reqs[k];
      wait_wr_en(ok);
      n_cmp++;
      if (!ok || grant_id !== exp_ids[k]) begin
        n_err++;
        $display("FAIL wrap_grant%0d got=%0d exp=%0d waited_ok=%0d", k, grant_id, exp_ids[k], ok);
      end
      done = 1'b1;
      step();
      done = 1'b0;
    end
    req = '0;
    step();
  endtask

  task automatic test_fifo_full();
    int bad = 0;
    do_reset();
    fifo_full = 1'b1;
    req = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      step();
      if (wr_en || busy) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL full_block got=%0d granted_cycles exp=0", bad);
    end
    fifo_full = 1'b0;
    step();
    n_cmp++;
    if ({wr_en, grant_id} !== {1'b1, 2'd1}) begin
      n_err++;
      $display("FAIL full_release got=%b exp=101", {wr_en, grant_id});
    end
    fifo_full = 1'b1;
    step();
    n_cmp++;
    if (wr_en !== 1'b1) begin
      n_err++;
      $display("FAIL full_no_abort got=%b exp=1", wr_en);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    n_cmp++;
    if (ack !== 4'b0010) begin
      n_err++;
      $display("FAIL full_ack got=%b exp=0010", ack);
    end
    fifo_full = 1'b0;
    req = '0;
    step();
  endtask

  task automatic test_timeout();
    bit ok;
    int hi = 0;
    do_reset();
    req = 4'b0011;
    step();
    for (int i = 0; i < 30 && wr_en; i++) begin
      hi++;
      step();
    end
    n_cmp++;
    if (hi != TIMEOUT + 1) begin
      n_err++;
      $display("FAIL to_wr_en_cycles got=%0d exp=%0d", hi, TIMEOUT + 1);
    end
    n_cmp++;
    if ({timeout_err, ack} !== 5'b10000) begin
      n_err++;
      $display("FAIL to_pulse got=%b exp=10000", {timeout_err, ack});
    end
    step();
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_err++;
      $display("FAIL to_single_pulse got=%b exp=0", timeout_err);
    end
    wait_wr_en(ok);
    n_cmp++;
    if (!ok || grant_id !== 2'd1) begin
      n_err++;
      $display("FAIL to_next_grant got=%0d exp=1 waited_ok=%0d", grant_id, ok);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    req = 4'b0001;
    wait_wr_en(ok);
    n_cmp++;
    if (!ok || grant_id !== 2'd0) begin
      n_err++;
      $display("FAIL to_retry got=%0d exp=0 waited_ok=%0d", grant_id, ok);
    end
    // Done arriving exactly on the timeout cycle must complete, not abort.
    for (int i = 0; i < TIMEOUT; i++) step();
    done = 1'b1;
    step();
    done = 1'b0;
    n_cmp++;
    if ({ack, timeout_err} !== 5'b00010) begin
      n_err++;
      $display("FAIL to_done_wins got=%b exp=00010", {ack, timeout_err});
    end
    req = '0;
    step();
  endtask

  task automatic test_rst_mid_write();
    bit ok;
    do_reset();
    req = 4'b0100;
    wait_wr_en(ok);
    done = 1'b1;
    step();
    done = 1'b0;
    req = 4'b0010;
    wait_wr_en(ok);
    n_cmp++;
    if (!ok || grant_id !== 2'd1) begin
      n_err++;
      $display("FAIL rst_pre_grant got=%0d exp=1 waited_ok=%0d", grant_id, ok);
    end
    step();
    rst = 1'b1;
    done = 1'b1;
    step();
    n_cmp++;
    if ({wr_en, ack, busy, timeout_err} !== 7'd0) begin
      n_err++;
      $display("FAIL rst_mid_write got=%b exp=0000000", {wr_en, ack, busy, timeout_err});
    end
    rst = 1'b0;
    done = 1'b0;
    req = 4'b1001;
    wait_wr_en(ok);
    n_cmp++;
    if (!ok || grant_id !== 2'd0) begin
      n_err++;
      $display("FAIL rst_next_grant got=%0d exp=0 waited_ok=%0d", grant_id, ok);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    req = '0;
    step();
  endtask

  task automatic test_random();
    logic [24:0] got, exp;
    int bad = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int ch = 0; ch < N_CH; ch++)
        if (!req[ch] && $urandom_range(0, 2) == 0) req[ch] = 1'b1;
      rst       = ($urandom_range(0, 399) == 0);
      fifo_full = ($urandom_range(0, 4) == 0);
      done      = ($urandom_range(0, 3) == 0);
      data_in   = {$urandom, $urandom};
      step();
      got = {wr_en, wr_data, grant_id, ack, timeout_err, busy};
      exp = {m_wr_en, m_data, 2'(m_gid), m_ack, m_to, (m_phase != 0)};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cycle%0d got=%h exp=%h", cyc, got, exp);
      end
      req = req & ~ack;
    end
    rst = 1'b0; req = '0; done = 1'b0; fifo_full = 1'b0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; done = 1'b0; fifo_full = 1'b0; data_in = '0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_wrap();
    test_fifo_full();
    test_timeout();
    test_rst_mid_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
